// File: rtl/lcd_char_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_writer_if
// Purpose  : Request/status interface between the register-display controller
//            (master) and the LCD character writer (slave).
// Signals  : I_START  - one-cycle refresh request (master -> slave)
//            I_WDATA0 - line-1 image, column 0 in [127:120]
//            I_WDATA1 - line-2 image, same packing
//            O_DONE   - one-cycle pulse when a refresh completes (slave -> master)
//            O_BUSY   - high whenever I_START would be ignored
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_char_writer_if;
    logic         I_START;
    logic [127:0] I_WDATA0;
    logic [127:0] I_WDATA1;
    logic         O_DONE;
    logic         O_BUSY;

    modport master (
        output I_START,
        output I_WDATA0,
        output I_WDATA1,
        input  O_DONE,
        input  O_BUSY
    );

    modport slave (
        input  I_START,
        input  I_WDATA0,
        input  I_WDATA1,
        output O_DONE,
        output O_BUSY
    );
endinterface
`default_nettype wire

// File: rtl/lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_writer
// Purpose  : Physical-bus engine for a 16x2 HD44780-compatible character LCD
//            in 8-bit write-only mode. Runs the power-up initialisation on its
//            own after reset, then on each refresh request rewrites both
//            display lines and pulses O_DONE.
// Ports    : I_CLK       - system clock (50 MHz)
//            I_RSTF      - asynchronous active-low reset
//            bus         - lcd_char_writer_if.slave (I_START, I_WDATA0/1,
//                          O_DONE, O_BUSY)
//            O_LCD_ON    - LCD power enable, 1 from the first clock after reset
//            O_LCD_EN    - LCD enable strobe
//            O_LCD_RS    - register select (0 = command, 1 = data)
//            O_LCD_RWF   - read/write select, always 0 (write)
//            O_LCD_DATA  - LCD data bus
// Options  : LCD_CLEAR_ON_START_EN - when defined, every refresh is prefixed
//            with a clear-display command (0x01) so stale characters are
//            erased; otherwise the display is overwritten in place.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_char_writer #(
    parameter int SETUP_CYC    = 4,        // RS/DATA stable before EN rises
    parameter int EN_CYC       = 25,       // EN high time
    parameter int WAIT_CYC     = 2500,     // wait after a normal write
    parameter int CLR_WAIT_CYC = 100000,   // wait after clear-display (0x01)
    parameter int PWR_WAIT_CYC = 1000000   // wait after reset before init
) (
    input  wire logic              I_CLK,
    input  wire logic              I_RSTF,
    lcd_char_writer_if.slave       bus,
    output logic                   O_LCD_ON,
    output logic                   O_LCD_EN,
    output logic                   O_LCD_RS,
    output logic                   O_LCD_RWF,
    output logic [7:0]             O_LCD_DATA
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The single phase counter is shared by every timed interval, so it is
    // sized for the longest one.
    localparam int c_max_cyc = max_of(max_of(max_of(SETUP_CYC, EN_CYC),
                                             max_of(WAIT_CYC, CLR_WAIT_CYC)),
                                      PWR_WAIT_CYC);
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

`ifdef LCD_CLEAR_ON_START_EN
    localparam int c_xfer_pre = 1;     // leading clear-display write
`else
    localparam int c_xfer_pre = 0;
`endif
    localparam int c_xfer_writes = 34 + c_xfer_pre;
    localparam int c_init_writes = 4;

    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_en_last    = c_cnt_w'(EN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last  = c_cnt_w'(WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(CLR_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_pwr_last   = c_cnt_w'(PWR_WAIT_CYC - 1);
    localparam logic [5:0]         c_init_last  = 6'(c_init_writes - 1);
    localparam logic [5:0]         c_xfer_last  = 6'(c_xfer_writes - 1);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_XFER     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Sub-phase of a single write (used in ST_INIT and ST_XFER)
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_WAIT  = 2'd2
    } phase_t;

    // ------------------------------------------------------------------------
    // Byte tables, returned as {RS, DATA}
    // ------------------------------------------------------------------------
    function automatic logic [8:0] init_byte(input logic [5:0] idx);
        logic [8:0] b;
        case (idx)
            6'd0:    b = 9'h038;   // 8-bit bus, 2 lines, 5x8 font
            6'd1:    b = 9'h00C;   // display on, cursor off
            6'd2:    b = 9'h001;   // clear display
            default: b = 9'h006;   // increment, no shift
        endcase
        return b;
    endfunction

    // k is the refresh write number with any leading clear removed:
    // 0 = line-1 address, 1..16 = line-1 columns, 17 = line-2 address,
    // 18..33 = line-2 columns. Column c lives at bits [8*(15-c) +: 8].
    function automatic logic [8:0] xfer_byte(input logic [5:0]   idx,
                                             input logic [127:0] l0,
                                             input logic [127:0] l1);
        int         k;
        logic [8:0] b;
        k = int'(idx) - c_xfer_pre;
        if (k < 0)
            b = 9'h001;
        else if (k == 0)
            b = 9'h080;
        else if (k <= 16)
            b = {1'b1, l0[8*(16-k) +: 8]};
        else if (k == 17)
            b = 9'h0C0;
        else if (k <= 33)
            b = {1'b1, l1[8*(33-k) +: 8]};
        else
            b = 9'h080;
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t               r_state,  w_state_nxt;
    phase_t               r_phase,  w_phase_nxt;
    logic [c_cnt_w-1:0]   r_cnt,    w_cnt_nxt;
    logic [5:0]           r_idx,    w_idx_nxt;
    logic                 r_rs,     w_rs_nxt;
    logic [7:0]           r_data,   w_data_nxt;
    logic [127:0]         r_line0,  w_line0_nxt;
    logic [127:0]         r_line1,  w_line1_nxt;
    logic                 r_lcd_on;

    logic [c_cnt_w-1:0]   w_wait_last;
    logic [5:0]           w_idx_inc;
    logic [8:0]           w_byte_nxt;

    // Post-write wait length depends on the byte currently on the bus.
    assign w_wait_last = (!r_rs && (r_data == 8'h01)) ? c_clr_last : c_wait_last;
    assign w_idx_inc   = r_idx + 6'd1;
    assign w_byte_nxt  = (r_state == ST_INIT) ? init_byte(w_idx_inc)
                                              : xfer_byte(w_idx_inc, r_line0, r_line1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_state  <= ST_PWR_WAIT;
            r_phase  <= PH_SETUP;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rs     <= 1'b0;
            r_data   <= 8'h00;
            r_line0  <= '0;
            r_line1  <= '0;
            r_lcd_on <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_rs     <= w_rs_nxt;
            r_data   <= w_data_nxt;
            r_line0  <= w_line0_nxt;
            r_line1  <= w_line1_nxt;
            r_lcd_on <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // RS/DATA are only reloaded when a new write begins, so they hold through
    // the PULSE and WAIT phases of the current write.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        w_line0_nxt = r_line0;
        w_line1_nxt = r_line1;

        case (r_state)
            ST_PWR_WAIT: begin
                if (r_cnt == c_pwr_last) begin
                    w_state_nxt             = ST_INIT;
                    w_phase_nxt             = PH_SETUP;
                    w_cnt_nxt               = '0;
                    w_idx_nxt               = '0;
                    {w_rs_nxt, w_data_nxt}  = init_byte(6'd0);
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            ST_INIT, ST_XFER: begin
                case (r_phase)
                    PH_SETUP: begin
                        if (r_cnt == c_setup_last) begin
                            w_phase_nxt = PH_PULSE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end
                    PH_PULSE: begin
                        if (r_cnt == c_en_last) begin
                            w_phase_nxt = PH_WAIT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end
                    PH_WAIT: begin
                        if (r_cnt == w_wait_last) begin
                            w_cnt_nxt   = '0;
                            w_phase_nxt = PH_SETUP;
                            if ((r_state == ST_INIT) && (r_idx == c_init_last)) begin
                                w_state_nxt = ST_IDLE;
                            end else if ((r_state == ST_XFER) && (r_idx == c_xfer_last)) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_idx_nxt              = w_idx_inc;
                                {w_rs_nxt, w_data_nxt} = w_byte_nxt;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end
                    default: begin
                        w_phase_nxt = PH_SETUP;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            ST_IDLE: begin
                // Line images are captured on the request cycle; later input
                // changes do not affect the refresh in progress.
                if (bus.I_START) begin
                    w_state_nxt            = ST_XFER;
                    w_phase_nxt            = PH_SETUP;
                    w_cnt_nxt              = '0;
                    w_idx_nxt              = '0;
                    w_line0_nxt            = bus.I_WDATA0;
                    w_line1_nxt            = bus.I_WDATA1;
                    {w_rs_nxt, w_data_nxt} = xfer_byte(6'd0, bus.I_WDATA0, bus.I_WDATA1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_PWR_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registers so that reset clears them at once
    // ------------------------------------------------------------------------
    assign O_LCD_ON    = r_lcd_on;
    assign O_LCD_EN    = ((r_state == ST_INIT) || (r_state == ST_XFER)) && (r_phase == PH_PULSE);
    assign O_LCD_RS    = r_rs;
    assign O_LCD_RWF   = 1'b0;
    assign O_LCD_DATA  = r_data;
    assign bus.O_DONE  = (r_state == ST_DONE);
    assign bus.O_BUSY  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_writer
// Purpose  : Self-checking bench for lcd_char_writer. Stimulus pushes the
//            expected bus writes and O_DONE times into queues; a monitor pops
//            and compares on every EN rising edge and every O_DONE cycle.
//            Cycle n is the cycle following the n-th clock edge after reset
//            release (edge 0 is the first one).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_char_writer;

    localparam int SETUP_CYC    = 2;
    localparam int EN_CYC       = 3;
    localparam int WAIT_CYC     = 5;
    localparam int CLR_WAIT_CYC = 20;
    localparam int PWR_WAIT_CYC = 50;

`ifdef LCD_CLEAR_ON_START_EN
    localparam bit CLR_ON_START = 1'b1;
`else
    localparam bit CLR_ON_START = 1'b0;
`endif

    typedef struct {
        bit       rs;
        bit [7:0] data;
        bit       first;      // first write of a sequence
        int       rise_cyc;   // expected EN rise cycle for a first write, -1 = unchecked
    } wr_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_on, lcd_en, lcd_rs, lcd_rwf;
    logic [7:0] lcd_data;

    lcd_char_writer_if bus();

    lcd_char_writer #(
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .WAIT_CYC    (WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC),
        .PWR_WAIT_CYC(PWR_WAIT_CYC)
    ) dut (
        .I_CLK     (clk),
        .I_RSTF    (rst_n),
        .bus       (bus),
        .O_LCD_ON  (lcd_on),
        .O_LCD_EN  (lcd_en),
        .O_LCD_RS  (lcd_rs),
        .O_LCD_RWF (lcd_rwf),
        .O_LCD_DATA(lcd_data)
    );

    always #5 clk = ~clk;

    int  n_pass  = 0;
    int  n_total = 0;
    int  cyc     = -1;
    wr_t exp_q[$];
    int  done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int wait_of(input bit rs, input bit [7:0] d);
        return (!rs && d == 8'h01) ? CLR_WAIT_CYC : WAIT_CYC;
    endfunction

    function automatic int cost_of(input bit rs, input bit [7:0] d);
        return SETUP_CYC + EN_CYC + wait_of(rs, d);
    endfunction

    // Pushes the init writes; returns the total cycles they take.
    task automatic push_init(output int total);
        logic [7:0] cmds [4];
        cmds  = '{8'h38, 8'h0C, 8'h01, 8'h06};
        total = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rs: 1'b0, data: cmds[i], first: (i == 0), rise_cyc: -1});
            total += cost_of(1'b0, cmds[i]);
        end
    endtask

    task automatic push_refresh(input logic [127:0] l0, input logic [127:0] l1,
                                input int start_cyc);
        logic [8:0] seq[$];
        int         total = 0;
        if (CLR_ON_START) seq.push_back(9'h001);
        seq.push_back(9'h080);
        for (int c = 0; c < 16; c++) seq.push_back({1'b1, l0[127-8*c -: 8]});
        seq.push_back(9'h0C0);
        for (int c = 0; c < 16; c++) seq.push_back({1'b1, l1[127-8*c -: 8]});
        for (int i = 0; i < seq.size(); i++) begin
            exp_q.push_back('{rs: seq[i][8], data: seq[i][7:0], first: (i == 0),
                              rise_cyc: start_cyc + SETUP_CYC});
            total += cost_of(seq[i][8], seq[i][7:0]);
        end
        done_q.push_back(start_cyc + total);
    endtask

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc = rst_n ? cyc + 1 : -1;
    end

    // ---------------- monitor ----------------
    bit  m_prev_en   = 1'b0;
    int  m_en_len    = 0;
    bit  m_have_prev = 1'b0;
    wr_t m_prev_w;
    wr_t m_e;
    int  m_prev_rise = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_prev_en   = 1'b0;
            m_en_len    = 0;
            m_have_prev = 1'b0;
        end else begin
            if (lcd_en) m_en_len++;
            if (lcd_en && !m_prev_en) begin
                check("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check("wr_rs_data", {lcd_rs, lcd_data}, {m_e.rs, m_e.data});
                    check("wr_rwf", lcd_rwf, 1'b0);
                    if (m_e.first && m_e.rise_cyc >= 0)
                        check("first_rise_cycle", cyc, m_e.rise_cyc);
                    if (!m_e.first && m_have_prev)
                        check("write_spacing", cyc - m_prev_rise,
                              cost_of(m_prev_w.rs, m_prev_w.data));
                    m_have_prev = 1'b1;
                    m_prev_w    = m_e;
                    m_prev_rise = cyc;
                end
            end
            if (!lcd_en && m_prev_en) begin
                check("en_width", m_en_len, EN_CYC);
                m_en_len = 0;
            end
            if (bus.O_DONE) begin
                check("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
            end
            m_prev_en = lcd_en;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (bus.O_BUSY !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.O_BUSY === 1'b0, 1);
    endtask

    // Releases reset at a negedge and follows the power-up sequence to IDLE.
    task automatic power_up();
        int  init_total;
        bit  en_seen = 1'b0;
        bit  off_seen = 1'b0;
        push_init(init_total);
        rst_n = 1'b1;
        for (int i = 0; i < PWR_WAIT_CYC; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0) en_seen = 1'b1;
            if (lcd_on !== 1'b1) off_seen = 1'b1;
        end
        check("pwr_wait_en_low", en_seen, 1'b0);
        check("lcd_on_after_release", off_seen, 1'b0);
        wait_idle(1000, "init_reaches_idle");
        check("busy_fall_cycle", cyc, PWR_WAIT_CYC - 1 + init_total);
        check("init_writes_left", exp_q.size(), 0);
    endtask

    // Issues a refresh from IDLE at a negedge; returns the edge that sampled it.
    task automatic do_refresh(input logic [127:0] l0, input logic [127:0] l1,
                              output int start_cyc);
        bus.I_WDATA0 = l0;
        bus.I_WDATA1 = l1;
        bus.I_START  = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        push_refresh(l0, l1, start_cyc);
        bus.I_START = 1'b0;
    endtask

    task automatic finish_refresh(input string name);
        wait_idle(2000, {name, "_idle"});
        check({name, "_writes_left"}, exp_q.size(), 0);
        check({name, "_done_left"}, done_q.size(), 0);
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] l0, l1, a_line;
        int           t;
        int           n;

        bus.I_START  = 1'b0;
        bus.I_WDATA0 = '0;
        bus.I_WDATA1 = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {lcd_on, lcd_en, lcd_rs, lcd_rwf, lcd_data, bus.O_DONE, bus.O_BUSY},
              {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});

        power_up();

        // Directed refresh; line-1 input is corrupted right after the latch.
        l0     = "Register Data   ";
        l1     = "0000ABCD        ";
        a_line = {16{8'h41}};
        do_refresh(l0, l1, t);
        @(negedge clk);
        bus.I_WDATA0 = a_line;
        check("busy_during_refresh", bus.O_BUSY, 1'b1);
        finish_refresh("directed");

        // Random refreshes with random idle gaps.
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_refresh(rand_line(), rand_line(), t);
            finish_refresh("random");
        end

        // Requests while busy and in the O_DONE cycle must be dropped.
        do_refresh(rand_line(), rand_line(), t);
        repeat (10 * (SETUP_CYC + EN_CYC + WAIT_CYC) + 1) @(negedge clk);
        bus.I_START = 1'b1;
        @(negedge clk);
        bus.I_START = 1'b0;
        check("busy_at_index10", bus.O_BUSY, 1'b1);
        n = 0;
        while (bus.O_DONE !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.O_DONE, 1'b1);
        check("busy_in_done_cycle", bus.O_BUSY, 1'b1);
        bus.I_START = 1'b1;
        @(negedge clk);
        check("busy_low_after_done", bus.O_BUSY, 1'b0);
        bus.I_START = 1'b0;
        repeat (400) @(negedge clk);
        check("no_extra_refresh", bus.O_BUSY, 1'b0);
        check("ignore_writes_left", exp_q.size(), 0);
        check("ignore_done_left", done_q.size(), 0);

        // Reset in the middle of a refresh, then full re-initialisation.
        do_refresh(rand_line(), rand_line(), t);
        repeat (20 * (SETUP_CYC + EN_CYC + WAIT_CYC) + SETUP_CYC + 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {lcd_on, lcd_en, lcd_rs, lcd_rwf, lcd_data, bus.O_DONE, bus.O_BUSY},
              {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        power_up();
        do_refresh(rand_line(), rand_line(), t);
        finish_refresh("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Backstop in case a bounded wait is somehow bypassed.
    initial begin
        #5_000_000;
        n_total++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
